// File: rtl/ccp_ctrl_wr_data_tx_if.sv
// CCP write-data channel from the ctrl side to the cache.
// The master drives the beat fields and the slave returns ready.
interface ccp_ctrl_wr_data_tx_if #(
  parameter int DATA_W      = 129,
  parameter int BYTE_EN_W   = (DATA_W - 1) / 8,
  parameter int BURST_LEN_W = 2
);
  logic                   ctrl_wr_valid;
  logic [DATA_W-1:0]      ctrl_wr_data;
  logic [BYTE_EN_W-1:0]   ctrl_wr_byte_en;
  logic [BURST_LEN_W-1:0] ctrl_wr_beat_num;
  logic                   ctrl_wr_last;
  logic                   ctrl_wr_bypass;
  logic                   cache_wr_ready;

  modport master (
    output ctrl_wr_valid, ctrl_wr_data, ctrl_wr_byte_en, ctrl_wr_beat_num,
           ctrl_wr_last, ctrl_wr_bypass,
    input  cache_wr_ready
  );

  modport slave (
    input  ctrl_wr_valid, ctrl_wr_data, ctrl_wr_byte_en, ctrl_wr_beat_num,
           ctrl_wr_last, ctrl_wr_bypass,
    output cache_wr_ready
  );
endinterface

// File: rtl/ccp_ctrl_wr_data_tx.sv
// Ctrl-side transmitter of the CCP write-data channel.
// Each p2 op that needs write data leaves a descriptor in a small FIFO; the
// head descriptor steers how upstream beats are numbered, masked and flagged
// as they are moved into the registered output stage towards the cache.
module ccp_ctrl_wr_data_tx #(
  parameter int DATA_W         = 129,
  parameter int BYTE_EN_W      = (DATA_W - 1) / 8,
  parameter int BURST_LEN_W    = 2,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   op_push,
  input  logic [BURST_LEN_W-1:0] op_burst_len,
  input  logic [BURST_LEN_W-1:0] op_start_beat,
  input  logic                   op_full,
  input  logic                   op_pure_bypass,
  output logic                   op_fifo_full,
  output logic                   op_overflow_err,
  input  logic                   src_valid,
  input  logic [DATA_W-1:0]      src_data,
  input  logic [BYTE_EN_W-1:0]   src_byte_en,
  output logic                   src_ready,
  ccp_ctrl_wr_data_tx_if.master  wr,
  output logic                   idle
);

  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [BURST_LEN_W-1:0] burst_len;
    logic [BURST_LEN_W-1:0] start_beat;
    logic                   full;
    logic                   pure_bypass;
  } cmd_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  cmd_t                   fifo_mem [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [BURST_LEN_W-1:0] cnt;
  cmd_t                   head;
  cmd_t                   push_cmd;
  state_t                 state;
  state_t                 state_next;
  logic                   out_free;
  logic                   load;
  logic                   is_last;
  logic                   pop;
  logic                   push_en;

  assign head     = fifo_mem[rd_ptr];
  assign push_cmd = '{burst_len: op_burst_len, start_beat: op_start_beat,
                      full: op_full, pure_bypass: op_pure_bypass};

  assign op_fifo_full = (count == CNT_W'(CMD_FIFO_DEPTH));
  assign idle         = (count == '0) && !wr.ctrl_wr_valid;

  // A full FIFO still takes a push when the head retires in the same cycle.
  always_comb begin
    pop        = load && is_last;
    push_en    = op_push && (!op_fifo_full || pop);
    count_next = count + CNT_W'(push_en) - CNT_W'(pop);
  end

  // Descriptor storage and pointers; the head only changes after an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push_en) begin
        fifo_mem[wr_ptr] <= push_cmd;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Sticky flag for descriptors lost to a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         op_overflow_err <= 1'b0;
    else if (op_push && op_fifo_full && !pop) op_overflow_err <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Stay in SEND while any descriptor is left after this cycle's push/pop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (count_next != '0) state_next = SEND;
      SEND: if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: accept upstream beats only when the output stage can take one.
  always_comb begin
    out_free  = !wr.ctrl_wr_valid || wr.cache_wr_ready;
    src_ready = (state == SEND) && out_free;
    load      = src_valid && src_ready;
    is_last   = (cnt == head.burst_len);
  end

  // Beat counter within the current burst, restarted when the last beat loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (load)  cnt <= is_last ? '0 : cnt + BURST_LEN_W'(1);
  end

  // Output stage: holds the beat until the cache takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr.ctrl_wr_valid    <= 1'b0;
      wr.ctrl_wr_data     <= '0;
      wr.ctrl_wr_byte_en  <= '0;
      wr.ctrl_wr_beat_num <= '0;
      wr.ctrl_wr_last     <= 1'b0;
      wr.ctrl_wr_bypass   <= 1'b0;
    end else if (load) begin
      wr.ctrl_wr_valid    <= 1'b1;
      wr.ctrl_wr_data     <= src_data;
      wr.ctrl_wr_byte_en  <= head.full ? '1 : src_byte_en;
      wr.ctrl_wr_beat_num <= head.start_beat + cnt;
      wr.ctrl_wr_last     <= is_last;
      wr.ctrl_wr_bypass   <= head.pure_bypass;
    end else if (wr.cache_wr_ready) begin
      wr.ctrl_wr_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ccp_ctrl_wr_data_tx.sv
// Self-checking bench for ccp_ctrl_wr_data_tx.
// A transaction-level model (queue of pending ops plus one held output beat)
// predicts every output each cycle; scenario tasks add directed checks.
module tb_ccp_ctrl_wr_data_tx;
  localparam int DATA_W      = 129;
  localparam int BYTE_EN_W   = (DATA_W - 1) / 8;
  localparam int BURST_LEN_W = 2;
  localparam int DEPTH       = 4;

  typedef struct {
    logic [1:0] len;
    logic [1:0] start;
    logic       full;
    logic       byp;
  } op_t;

  logic                 clk;
  logic                 reset_n;
  logic                 op_push;
  logic [1:0]           op_burst_len;
  logic [1:0]           op_start_beat;
  logic                 op_full;
  logic                 op_pure_bypass;
  logic                 op_fifo_full;
  logic                 op_overflow_err;
  logic                 src_valid;
  logic [DATA_W-1:0]    src_data;
  logic [BYTE_EN_W-1:0] src_byte_en;
  logic                 src_ready;
  logic                 idle;

  ccp_ctrl_wr_data_tx_if #(.DATA_W(DATA_W), .BYTE_EN_W(BYTE_EN_W),
                           .BURST_LEN_W(BURST_LEN_W)) wr_if ();

  ccp_ctrl_wr_data_tx #(
    .DATA_W(DATA_W), .BYTE_EN_W(BYTE_EN_W),
    .BURST_LEN_W(BURST_LEN_W), .CMD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .op_push(op_push), .op_burst_len(op_burst_len), .op_start_beat(op_start_beat),
    .op_full(op_full), .op_pure_bypass(op_pure_bypass),
    .op_fifo_full(op_fifo_full), .op_overflow_err(op_overflow_err),
    .src_valid(src_valid), .src_data(src_data), .src_byte_en(src_byte_en),
    .src_ready(src_ready), .wr(wr_if.master), .idle(idle)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  op_t                  mq[$];
  int                   m_idx;
  logic                 m_valid;
  logic [DATA_W-1:0]    m_data;
  logic [BYTE_EN_W-1:0] m_be;
  logic [1:0]           m_bn;
  logic                 m_last;
  logic                 m_byp;
  logic                 m_err;

  // observations of accepted beats and of the last sampled cycle
  logic [1:0]           obs_bn[$];
  logic                 obs_last[$];
  logic [BYTE_EN_W-1:0] obs_be[$];
  int                   obs_cyc[$];
  logic                 s_valid, s_src_ready, s_full, s_err;
  logic [DATA_W-1:0]    s_data;
  logic [1:0]           s_bn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_idx = 0; m_valid = 0; m_data = '0; m_be = '0; m_bn = '0;
    m_last = 0; m_byp = 0; m_err = 0;
  endtask

  task automatic obs_clear();
    obs_bn.delete(); obs_last.delete(); obs_be.delete(); obs_cyc.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model to the next rising edge.
  task automatic run_cycle(input logic push, input logic [1:0] len, input logic [1:0] start,
                           input logic full, input logic byp, input logic sv,
                           input logic [BYTE_EN_W-1:0] be, input logic rdy);
    logic [159:0] rnd;
    logic exp_sready, load, pop, was_full;
    op_t h, n;
    @(negedge clk);
    cyc++;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    op_push = push; op_burst_len = len; op_start_beat = start;
    op_full = full; op_pure_bypass = byp;
    src_valid = sv; src_data = rnd[DATA_W-1:0]; src_byte_en = be;
    wr_if.cache_wr_ready = rdy;
    #1;
    exp_sready = (mq.size() != 0) && (!m_valid || rdy);
    checks++;
    if (wr_if.ctrl_wr_valid !== m_valid) begin
      errors++; $display("[TB] FAIL valid cyc%0d: got %b expected %b", cyc, wr_if.ctrl_wr_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (wr_if.ctrl_wr_data !== m_data) begin
        errors++; $display("[TB] FAIL data cyc%0d: got %h expected %h", cyc, wr_if.ctrl_wr_data, m_data);
      end
      checks++;
      if (wr_if.ctrl_wr_byte_en !== m_be) begin
        errors++; $display("[TB] FAIL byte_en cyc%0d: got %h expected %h", cyc, wr_if.ctrl_wr_byte_en, m_be);
      end
      checks++;
      if (wr_if.ctrl_wr_beat_num !== m_bn) begin
        errors++; $display("[TB] FAIL beat_num cyc%0d: got %0d expected %0d", cyc, wr_if.ctrl_wr_beat_num, m_bn);
      end
      checks++;
      if (wr_if.ctrl_wr_last !== m_last) begin
        errors++; $display("[TB] FAIL last cyc%0d: got %b expected %b", cyc, wr_if.ctrl_wr_last, m_last);
      end
      checks++;
      if (wr_if.ctrl_wr_bypass !== m_byp) begin
        errors++; $display("[TB] FAIL bypass cyc%0d: got %b expected %b", cyc, wr_if.ctrl_wr_bypass, m_byp);
      end
    end
    checks++;
    if (src_ready !== exp_sready) begin
      errors++; $display("[TB] FAIL src_ready cyc%0d: got %b expected %b", cyc, src_ready, exp_sready);
    end
    checks++;
    if (op_fifo_full !== (mq.size() == DEPTH)) begin
      errors++; $display("[TB] FAIL fifo_full cyc%0d: got %b expected %b", cyc, op_fifo_full, mq.size() == DEPTH);
    end
    checks++;
    if (op_overflow_err !== m_err) begin
      errors++; $display("[TB] FAIL overflow_err cyc%0d: got %b expected %b", cyc, op_overflow_err, m_err);
    end
    checks++;
    if (idle !== (mq.size() == 0 && !m_valid)) begin
      errors++; $display("[TB] FAIL idle cyc%0d: got %b expected %b", cyc, idle, mq.size() == 0 && !m_valid);
    end
    s_valid = wr_if.ctrl_wr_valid; s_src_ready = src_ready; s_full = op_fifo_full;
    s_err = op_overflow_err; s_data = wr_if.ctrl_wr_data; s_bn = wr_if.ctrl_wr_beat_num;
    if (wr_if.ctrl_wr_valid === 1'b1 && rdy) begin
      obs_bn.push_back(wr_if.ctrl_wr_beat_num);
      obs_last.push_back(wr_if.ctrl_wr_last);
      obs_be.push_back(wr_if.ctrl_wr_byte_en);
      obs_cyc.push_back(cyc);
    end
    // model advance
    was_full = (mq.size() == DEPTH);
    load = exp_sready && sv;
    pop  = 0;
    if (load) begin
      h       = mq[0];
      m_valid = 1;
      m_data  = src_data;
      m_be    = h.full ? '1 : be;
      m_bn    = 2'((int'(h.start) + m_idx) % 4);
      m_last  = (m_idx == int'(h.len));
      m_byp   = h.byp;
      if (m_last) begin
        pop = 1; void'(mq.pop_front()); m_idx = 0;
      end else m_idx++;
    end else if (rdy) m_valid = 0;
    if (push) begin
      if (!was_full || pop) begin
        n.len = len; n.start = start; n.full = full; n.byp = byp;
        mq.push_back(n);
      end else m_err = 1;
    end
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 0, '0, 1);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_clear();
    obs_clear();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op_push = 0; op_burst_len = 0; op_start_beat = 0; op_full = 0;
    op_pure_bypass = 0; src_valid = 0; src_data = '0; src_byte_en = '0;
    wr_if.cache_wr_ready = 1'b0;
    #3;
    checks++;
    if (wr_if.ctrl_wr_valid !== 1'b0 || wr_if.ctrl_wr_last !== 1'b0 || wr_if.ctrl_wr_bypass !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got v=%b l=%b b=%b expected 0", wr_if.ctrl_wr_valid, wr_if.ctrl_wr_last, wr_if.ctrl_wr_bypass);
    end
    checks++;
    if (wr_if.ctrl_wr_data !== '0 || wr_if.ctrl_wr_byte_en !== '0 || wr_if.ctrl_wr_beat_num !== '0) begin
      errors++; $display("[TB] FAIL reset_fields: got be=%h bn=%0d expected 0", wr_if.ctrl_wr_byte_en, wr_if.ctrl_wr_beat_num);
    end
    checks++;
    if (idle !== 1'b1 || src_ready !== 1'b0 || op_fifo_full !== 1'b0 || op_overflow_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status: got idle=%b srdy=%b full=%b err=%b expected 1000", idle, src_ready, op_fifo_full, op_overflow_err);
    end
    #4 reset_n = 1'b1;
    model_clear();
    obs_clear();
    idle_cycles(2);
  endtask

  task automatic test_single_burst();
    logic [1:0] exp_bn[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int push_cyc;
    do_reset();
    run_cycle(1, 2'd3, 2'd0, 0, 0, 0, 16'h1234, 1);
    push_cyc = cyc;
    for (int i = 0; i < 6; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h1234, 1);
    checks++;
    if (obs_bn.size() != 4) begin
      errors++; $display("[TB] FAIL single_count: got %0d expected 4", obs_bn.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_bn[i] !== exp_bn[i] || obs_last[i] !== (i == 3) || obs_cyc[i] != push_cyc + 2 + i) begin
          errors++; $display("[TB] FAIL single_beat%0d: got bn=%0d last=%b cyc=%0d expected bn=%0d last=%b cyc=%0d",
                             i, obs_bn[i], obs_last[i], obs_cyc[i], exp_bn[i], i == 3, push_cyc + 2 + i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_bn[4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    run_cycle(1, 2'd3, 2'd2, 0, 1, 0, 16'h0001, 1);
    for (int i = 0; i < 6; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0001, 1);
    checks++;
    if (obs_bn.size() != 4) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d expected 4", obs_bn.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_bn[i] !== exp_bn[i] || obs_last[i] !== (i == 3)) begin
          errors++; $display("[TB] FAIL wrap_beat%0d: got bn=%0d last=%b expected bn=%0d last=%b",
                             i, obs_bn[i], obs_last[i], exp_bn[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held_data;
    logic [1:0]        held_bn;
    do_reset();
    run_cycle(1, 2'd3, 2'd0, 0, 0, 0, 16'h00FF, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00FF, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00FF, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00FF, 0);
    held_data = s_data; held_bn = s_bn;
    for (int i = 0; i < 2; i++) begin
      run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00FF, 0);
      checks++;
      if (s_valid !== 1'b1 || s_data !== held_data || s_bn !== held_bn || s_src_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got v=%b bn=%0d srdy=%b expected v=1 bn=%0d srdy=0",
                           i, s_valid, s_bn, s_src_ready, held_bn);
      end
    end
    for (int i = 0; i < 5; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00FF, 1);
    checks++;
    if (obs_bn.size() != 4 || obs_bn[0] !== 2'd0 || obs_bn[3] !== 2'd3 || obs_last[3] !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_no_loss: got %0d beats expected 4 ending with beat 3 last", obs_bn.size());
    end
  endtask

  task automatic test_full_byte_en();
    do_reset();
    run_cycle(1, 2'd2, 2'd1, 1, 0, 0, 16'h00F0, 1);
    for (int i = 0; i < 5; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h00F0, 1);
    checks++;
    if (obs_be.size() != 3) begin
      errors++; $display("[TB] FAIL full_be_count: got %0d expected 3", obs_be.size());
    end
    foreach (obs_be[i]) begin
      checks++;
      if (obs_be[i] !== 16'hFFFF) begin
        errors++; $display("[TB] FAIL full_be%0d: got %h expected ffff", i, obs_be[i]);
      end
    end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(1, 2'd0, 2'(i), 0, 0, 0, 16'h0, 1);
    idle_cycles(1);
    checks++;
    if (s_full !== 1'b1 || s_err !== 1'b0) begin
      errors++; $display("[TB] FAIL fill4: got full=%b err=%b expected full=1 err=0", s_full, s_err);
    end
    run_cycle(1, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 0, 16'h0, 0);
    checks++;
    if (s_full !== 1'b1 || s_err !== 1'b0) begin
      errors++; $display("[TB] FAIL push_pop_full: got full=%b err=%b expected full=1 err=0", s_full, s_err);
    end
    run_cycle(1, 2'd0, 2'd0, 0, 0, 0, 16'h0, 0);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 0, 16'h0, 0);
    checks++;
    if (s_err !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_set: got err=%b expected 1", s_err);
    end
    run_cycle(1, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 0, 16'h0, 1);
    checks++;
    if (s_err !== 1'b1 || s_full !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_sticky: got err=%b full=%b expected 1 1", s_err, s_full);
    end
    for (int i = 0; i < 8; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    run_cycle(1, 2'd3, 2'd1, 0, 0, 0, 16'h0, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (wr_if.ctrl_wr_valid !== 1'b0 || idle !== 1'b1 || src_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid: got v=%b idle=%b srdy=%b expected 0 1 0", wr_if.ctrl_wr_valid, idle, src_ready);
    end
    #1 reset_n = 1'b1;
    model_clear();
    obs_clear();
    run_cycle(1, 2'd1, 2'd3, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    checks++;
    if (obs_bn.size() != 2 || obs_bn[0] !== 2'd3 || obs_bn[1] !== 2'd0) begin
      errors++; $display("[TB] FAIL after_reset_burst: got %0d beats expected beat_num 3 then 0", obs_bn.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                16'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 30; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'($urandom), 1);
  endtask

  task automatic test_back_to_back();
    int first_b;
    do_reset();
    run_cycle(1, 2'd1, 2'd0, 0, 0, 0, 16'h0, 1);
    run_cycle(1, 2'd1, 2'd2, 0, 1, 1, 16'h0, 1);
    for (int i = 0; i < 6; i++) run_cycle(0, 2'd0, 2'd0, 0, 0, 1, 16'h0, 1);
    checks++;
    if (obs_bn.size() != 4) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", obs_bn.size());
    end else begin
      first_b = obs_cyc[0];
      checks++;
      if (obs_cyc[3] != first_b + 3 || obs_bn[2] !== 2'd2 || obs_last[1] !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_no_bubble: got last cyc %0d bn2=%0d expected cyc %0d bn2=2",
                           obs_cyc[3], obs_bn[2], first_b + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_backpressure();
    test_full_byte_en();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
